// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, WIDTH data bits, stop bit.
// Define SERIAL_FRAME_TX_PARITY_EN to insert an even-parity bit between data and stop.
module serial_frame_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dataout,
    output logic             busy,
    output logic             done
);

    localparam int             CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

`ifdef SERIAL_FRAME_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             cur_bit;
    logic [WIDTH-1:0] sreg_shift;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic             par;
`endif

    assign din_ready  = (state == IDLE) || (state == STOP);
    assign accept     = din_valid && din_ready;
    assign cur_bit    = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    assign sreg_shift = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

    // dataout always shows the bit of the current state; the next bit is
    // loaded on the edge that enters the following state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            dataout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, STOP: begin
                    done <= 1'b0;
                    if (accept) begin
                        state   <= START;
                        sreg    <= din;
                        cnt     <= '0;
                        dataout <= 1'b0;
                        busy    <= 1'b1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        par     <= ^din;
`endif
                    end else begin
                        state   <= IDLE;
                        dataout <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                START: begin
                    state   <= DATA;
                    dataout <= cur_bit;
                    sreg    <= sreg_shift;
                end
                DATA: begin
                    if (cnt == LAST) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        state   <= PARITY;
                        dataout <= par;
`else
                        state   <= STOP;
                        dataout <= 1'b1;
                        done    <= 1'b1;
`endif
                    end else begin
                        cnt     <= cnt + 1'b1;
                        dataout <= cur_bit;
                        sreg    <= sreg_shift;
                    end
                end
`ifdef SERIAL_FRAME_TX_PARITY_EN
                PARITY: begin
                    state   <= STOP;
                    dataout <= 1'b1;
                    done    <= 1'b1;
                end
`endif
                default: begin
                    state   <= IDLE;
                    dataout <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Parallel-in, serial-out frame transmitter. It is the transmit end of the single-wire serial link whose receive side is the existing serial-in shift-register chain.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Emits a start bit, the data bits, and a stop bit on `dataout`, one bit per `clk` cycle.
- Sits between a parallel producer (register file or FIFO) and the serial line.

Parameters:
- WIDTH, 4: data bits per frame; legal range 2..32.
- MSB_FIRST, 0: 0 = LSB transmitted first; 1 = MSB transmitted first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- din  input  WIDTH  parallel word to send; must stay stable while din_valid=1 and din_ready=0.
- din_valid  input  1  producer has a word.
- din_ready  output  1  transmitter can accept a word this cycle.
- dataout  output  1  serial line; idles high.
- busy  output  1  frame in progress (START, DATA, PARITY or STOP state).
- done  output  1  one-cycle pulse during the stop-bit cycle.

Behaviour:
- Reset asserted (reset=0), asynchronously:
  - state=IDLE, dataout=1, busy=0, done=0.
  - shift register=0, bit counter=0.
  - din_ready=1.
  - Deasserting reset resumes in IDLE.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is built in).
- din_ready is a combinational function of state: 1 in IDLE or STOP, else 0.
- Accept condition: din_valid && din_ready at a rising edge (edge E0).
  - Captures din into the shift register.
  - Clears the bit counter.
  - Moves to START.
- Frame timing; all outputs are registered, and dataout changes only on rising edges:
  - Cycle after E0: START, dataout=0.
  - Next WIDTH cycles: DATA, dataout = current data bit.
    - MSB_FIRST=0: bit 0 first, shift right.
    - MSB_FIRST=1: bit WIDTH-1 first, shift left.
  - Counter runs 0..WIDTH-1 and is $clog2(WIDTH) bits wide. DATA→STOP when counter==WIDTH-1; the counter never wraps within a frame.
  - STOP: dataout=1, done=1 for exactly that cycle.
  - Frame length: WIDTH+2 cycles (no parity).
- STOP exit:
  - If din_valid=1, accept and go directly to START. Back-to-back frames have zero idle gap.
  - Otherwise go to IDLE. dataout stays 1, done returns to 0.
- busy=1 from the first START cycle through the last STOP cycle; 0 in IDLE.
- din_valid outside IDLE/STOP is ignored. The word is not lost: the producer holds it until the handshake completes.
- din changes while din_ready=0 have no effect on the frame in flight.
- Reset mid-frame:
  - Frame aborts immediately; dataout=1 and busy=0 asynchronously.
  - done does not pulse.
  - The partial word is discarded.
- Simultaneous reset and accept: reset wins; no capture.

Optional Feature:
- Macro: SERIAL_FRAME_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - dataout in that cycle = XOR of all WIDTH captured data bits (even parity: total ones in data+parity is even).
  - Parity is computed from the captured word at accept time.
  - Frame length becomes WIDTH+3; done still pulses only in STOP.
- Undefined: no PARITY state and no parity logic; frame length WIDTH+2.

Test Plan:
1. WIDTH=4, MSB_FIRST=0, after reset release: din=4'b1011 with din_valid pulsed while idle → dataout over 6 cycles = 0,1,1,0,1,1. done=1 only in the 6th cycle. busy high for 6 cycles. din_ready=0 during cycles 1-5.
2. Back-to-back: hold din_valid=1, sending 4'b0001 then 4'b1110 (din switched on the accept edge) → 12 contiguous cycles: 0,1,0,0,0,1,0,0,1,1,1,1. No idle high between the frames other than the stop bit.
3. MSB_FIRST=1, din=4'b1000 → dataout = 0,1,0,0,0,1.
4. Reset mid-frame: start 4'b0101, drive reset=0 during the 3rd data cycle → dataout=1 and busy=0 immediately, no done pulse. After release, a new word 4'b1111 transmits correctly: 0,1,1,1,1,1.
5. din_valid pulsed with din=4'b0110 while busy=1 and dropped before STOP → ignored; only the original frame is sent, then the line idles at 1.
6. SERIAL_FRAME_TX_PARITY_EN defined, din=4'b1011 → dataout = 0,1,1,0,1,1,1 (parity bit=1). done in the 7th cycle. With din=4'b0011, parity bit=0.
